mem_unit: RTL

Program/data memory stage directly downstream of the CPU's memory port. It consumes the CPU's 16-bit address, 8-bit write data and read/write strobes, and returns read data on the CPU's `data_in`. It also provides a byte-serial loader so a program can be written from the panel before execution, gated by the same 2-bit `cpustate` the CPU uses. It sits between the CPU and the board switch/debounce logic.

---
 rtl/mem_unit.sv | 65 ++++++
 1 files changed

// File: rtl/mem_unit.sv
// mem_unit: CPU program/data RAM with a panel byte-serial loader and out-of-range flag.
module mem_unit #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cpustate,
  input  logic [15:0]   addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          read,
  input  logic          write,
  output logic [7:0]    cpu_rdata,
  input  logic [7:0]    load_data,
  input  logic          load_valid,
  output logic          load_ack,
  output logic [AW-1:0] load_ptr,
  output logic          load_full,
  output logic          oob
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  state_t state, next;
  logic [7:0] mem [DEPTH];
  logic lv_q, in_range, accept, we;
  logic [AW-1:0] idx, wa;
  logic [7:0] wd;
  always_comb begin
    next = cpustate == 2'b01 ? S_LOAD : cpustate == 2'b10 ? S_RUN : S_IDLE;
    idx = addr[AW-1:0];
    in_range = (addr >> AW) == 16'd0;
    accept = state == S_LOAD && load_valid && !lv_q && !load_full;
    we = accept || (state == S_RUN && write && in_range);
    wa = accept ? load_ptr : idx;
    wd = accept ? load_data : cpu_wdata;
    // read sees pre-write contents when read and write coincide
    cpu_rdata = (state == S_RUN && read && in_range) ? mem[idx] : 8'h00;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      lv_q <= 1'b1;
      load_ack <= 1'b0;
      load_ptr <= '0;
      load_full <= 1'b0;
      oob <= 1'b0;
    end else begin
      state <= next;
      lv_q <= load_valid;
      load_ack <= accept;
      if (next == S_LOAD && state != S_LOAD) begin
        load_ptr <= '0;
        load_full <= 1'b0;
        oob <= 1'b0;
      end else begin
        if (accept) begin
          load_ptr <= load_ptr + 1'b1;
          if (&load_ptr) load_full <= 1'b1;
        end
        if (state == S_RUN && (read || write) && !in_range) oob <= 1'b1;
      end
    end
  end
endmodule
